// File: rtl/axi4lite_pkg.sv
// Shared types for the AXI4-Lite single-outstanding command master.
package axi4lite_pkg;

  localparam int STRB_WIDTH = 4;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_RSP
  } mst_state_e;

endpackage

// File: rtl/axi4lite_master.sv
// AXI4-Lite master: turns one command request at a time into an AXI read or
// write transaction and returns the completion on the rsp_* interface.
//
// state      | meaning
// IDLE       | ready for a new command
// WR_REQ     | AW and W offered, each dropped after its own handshake
// WR_RESP    | waiting for B
// RD_REQ     | AR offered
// RD_DATA    | waiting for R
// RSP        | completion held until rsp_ready
module axi4lite_master
  import axi4lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic [STRB_WIDTH-1:0] WSTRB,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY
);

  mst_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  is_wr_q;
  logic                  aw_done_q;
  logic                  w_done_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  axi_resp_e             resp_q;

  logic req_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire;

  assign req_fire = req_valid && req_ready;
  assign aw_fire  = AWVALID && AWREADY;
  assign w_fire   = WVALID && WREADY;
  assign b_fire   = BVALID && BREADY;
  assign ar_fire  = ARVALID && ARREADY;
  assign r_fire   = RVALID && RREADY;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (req_fire) state_d = req_is_wr ? ST_WR_REQ : ST_RD_REQ;
      // AW and W may complete in either order or together
      ST_WR_REQ:  if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = ST_WR_RESP;
      ST_WR_RESP: if (b_fire) state_d = ST_RSP;
      ST_RD_REQ:  if (ar_fire) state_d = ST_RD_DATA;
      ST_RD_DATA: if (r_fire) state_d = ST_RSP;
      ST_RSP:     if (rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    BREADY    = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      // held off while reset is asserted so nothing is accepted then
      ST_IDLE:    req_ready = !ARESET;
      ST_WR_REQ: begin
        AWVALID = !aw_done_q;
        WVALID  = !w_done_q;
      end
      ST_WR_RESP: BREADY    = 1'b1;
      ST_RD_REQ:  ARVALID   = 1'b1;
      ST_RD_DATA: RREADY    = 1'b1;
      ST_RSP:     rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      is_wr_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
    end else begin
      if (req_fire) begin
        addr_q    <= req_addr;
        wdata_q   <= req_wdata;
        wstrb_q   <= req_wstrb;
        is_wr_q   <= req_is_wr;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_fire) aw_done_q <= 1'b1;
        if (w_fire)  w_done_q  <= 1'b1;
      end
      if (b_fire || r_fire) begin
        rdata_q <= is_wr_q ? '0 : RDATA;
        resp_q  <= axi_resp_e'(is_wr_q ? BRESP : RRESP);
      end
    end
  end

  assign AWADDR    = addr_q;
  assign ARADDR    = addr_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

endmodule
